stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter FRECUENCY, default 10000000: clk cycles per count tick (>=2).
REQ-002 The block SHALL have parameter NBITS, default 4: width of each BCD digit.
REQ-003 The block SHALL have parameter MAXIMUM_VALUE, default 4'h9: top value of each digit.
REQ-004 The block SHALL have port clk, input, 1: the single system clock; all state is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port btn_start_stop, input, 1: asynchronous level from a push button.
REQ-007 The block SHALL have port btn_lap, input, 1: asynchronous level from a push button.
REQ-008 The block SHALL have port btn_clear, input, 1: asynchronous level from a push button.
REQ-009 The block SHALL have port counter_u, input, NBITS: live units digit from the counter datapath.
REQ-010 The block SHALL have port counter_d, input, NBITS: live tens digit from the counter datapath.
REQ-011 The block SHALL have port count_enable, output, 1: one-cycle strobe that advances the counter by one.
REQ-012 The block SHALL have port count_clear, output, 1: one-cycle strobe that zeroes the counter.
REQ-013 The block SHALL have ports display_u and display_d, output, NBITS each: the digits to be shown.
REQ-014 The block SHALL have port state, output, 2: IDLE=00, RUN=01, PAUSE=10, LAP=11.
REQ-015 The block SHALL have port full, output, 1: high when the count has saturated at the top value.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-017 Each button press SHALL produce exactly one 1-cycle press event, on the 3rd rising clk edge after the button rises.
REQ-018 A held button SHALL produce no further press events.
REQ-019 The prescaler SHALL count 0..FRECUENCY-1 and wrap while state is RUN or LAP.
REQ-020 The prescaler SHALL be forced to 0 in IDLE and PAUSE.
REQ-021 count_enable SHALL be high for exactly one cycle when the prescaler equals FRECUENCY-1 in RUN or LAP, unless the saturation condition of REQ-027 holds.
REQ-022 Press-event priority in the same cycle SHALL be clear > start_stop > lap; lower-priority events in that cycle are discarded.
REQ-023 In IDLE: start_stop SHALL go to RUN; clear SHALL pulse count_clear and stay in IDLE; lap SHALL be ignored.
REQ-024 In RUN: start_stop SHALL go to PAUSE; lap SHALL capture counter_u/counter_d into the lap registers and go to LAP; clear SHALL be ignored.
REQ-025 In LAP: lap SHALL go to RUN; start_stop SHALL go to PAUSE; clear SHALL be ignored.
REQ-026 In PAUSE: start_stop SHALL go to RUN if full=0 and be ignored if full=1; clear SHALL pulse count_clear, set full=0 and go to IDLE; lap SHALL be ignored.
REQ-027 Saturation: at a tick in RUN or LAP with counter_d==MAXIMUM_VALUE and counter_u==MAXIMUM_VALUE, count_enable SHALL stay low, full SHALL be set and state SHALL go to PAUSE (no wrap to 00).
REQ-028 display_u/display_d SHALL show the lap registers in LAP and the live counter_u/counter_d in every other state (combinational mux).
REQ-029 count_clear SHALL be high for exactly one cycle, in the cycle after the clear press event.
REQ-030 count_enable and count_clear SHALL never be high in the same cycle.

Reset
REQ-031 On reset low, immediately and independent of clk, the block SHALL set: state=IDLE, prescaler=0, lap registers=0, full=0, count_enable=0, count_clear=0, synchronizer and edge flops=0.
REQ-032 A reset asserted mid-operation, in any state, SHALL abort it with no count_enable or count_clear pulse generated.
REQ-033 After reset releases, the first press event SHALL be honoured no earlier than 3 edges later.

Verification (FRECUENCY=4)
REQ-034 Scenario 1: reset, start_stop press -> state=01; count_enable pulses every 4th cycle; stop press -> state=10 with no further pulses.
REQ-035 Scenario 2: RUN with counter=3,7; lap press -> state=11 and display=3,7 frozen while counter advances; lap press -> state=01 and display follows live counter.
REQ-036 Scenario 3: counter=9,9 in RUN at tick -> count_enable=0, full=1, state=10; start_stop press ignored; clear -> count_clear pulse, full=0, state=00.
REQ-037 Scenario 4: clear and start_stop pressed in the same cycle in PAUSE -> only clear is honoured, state=00.
REQ-038 Scenario 5: button held high for 20 cycles -> exactly one press event; button glitch synchronized correctly at the 3-edge latency.
REQ-039 Scenario 6: reset low in LAP mid-prescale -> all outputs 0 asynchronously and state=00; no strobe after release without a press.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button synchronisation, run/pause/lap FSM, count tick prescaler
// and saturation at the top displayable value.
module stopwatch_ctrl #(
  parameter int unsigned      FRECUENCY     = 10000000,
  parameter int unsigned      NBITS         = 4,
  parameter logic [NBITS-1:0] MAXIMUM_VALUE = 4'h9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start_stop,
  input  logic             btn_lap,
  input  logic             btn_clear,
  input  logic [NBITS-1:0] counter_u,
  input  logic [NBITS-1:0] counter_d,
  output logic             count_enable,
  output logic             count_clear,
  output logic [NBITS-1:0] display_u,
  output logic [NBITS-1:0] display_d,
  output logic [1:0]       state,
  output logic             full
);

  localparam int unsigned PW = (FRECUENCY > 1) ? $clog2(FRECUENCY) : 1;
  localparam logic [PW-1:0] PresLast = PW'(FRECUENCY - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StLap   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [NBITS-1:0] lap_u_q, lap_u_d, lap_d_q, lap_d_d;
  logic             full_q, full_d;
  logic             enable_q, enable_d, clear_q, clear_d;

  // Button bits packed as {clear, start_stop, lap}.
  logic [2:0] sync1_q, sync2_q, prev_q, press;
  logic       ev_clear, ev_ss, ev_lap;
  logic       counting, tick, sat;

  assign press    = sync2_q & ~prev_q;
  assign ev_clear = press[2];
  assign ev_ss    = press[1] & ~press[2];
  assign ev_lap   = press[0] & ~press[1] & ~press[2];

  assign counting = (state_q == StRun) || (state_q == StLap);
  assign tick     = counting && (presc_q == PresLast);
  assign sat      = tick && (counter_u == MAXIMUM_VALUE) && (counter_d == MAXIMUM_VALUE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      lap_u_q  <= '0;
      lap_d_q  <= '0;
      full_q   <= 1'b0;
      enable_q <= 1'b0;
      clear_q  <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      lap_u_q  <= lap_u_d;
      lap_d_q  <= lap_d_d;
      full_q   <= full_d;
      enable_q <= enable_d;
      clear_q  <= clear_d;
      sync1_q  <= {btn_clear, btn_start_stop, btn_lap};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
    end
  end

  // Saturation outranks button events in the counting states.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!ev_clear && ev_ss) state_d = StRun;
      end
      StRun: begin
        if (sat || ev_ss) state_d = StPause;
        else if (ev_lap)  state_d = StLap;
      end
      StLap: begin
        if (sat || ev_ss) state_d = StPause;
        else if (ev_lap)  state_d = StRun;
      end
      StPause: begin
        if (ev_clear)            state_d = StIdle;
        else if (ev_ss && !full_q) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    lap_u_d  = lap_u_q;
    lap_d_d  = lap_d_q;
    full_d   = full_q;
    clear_d  = 1'b0;
    enable_d = tick && !sat;
    presc_d  = '0;
    // Prescaler only runs while staying within RUN/LAP, so entry and exit both restart at 0.
    if (counting && ((state_d == StRun) || (state_d == StLap))) begin
      presc_d = (presc_q == PresLast) ? '0 : presc_q + 1'b1;
    end
    if (sat) full_d = 1'b1;
    if ((state_q == StRun) && !sat && !ev_ss && ev_lap) begin
      lap_u_d = counter_u;
      lap_d_d = counter_d;
    end
    if (ev_clear && ((state_q == StIdle) || (state_q == StPause))) begin
      clear_d = 1'b1;
      full_d  = 1'b0;
    end
  end

  assign state        = state_q;
  assign full         = full_q;
  assign count_enable = enable_q;
  assign count_clear  = clear_q;
  assign display_u    = (state_q == StLap) ? lap_u_q : counter_u;
  assign display_d    = (state_q == StLap) ? lap_d_q : counter_d;

endmodule
